// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the round-robin ROM read-port arbiter.
// Holds the FSM state encoding, default geometry and the index-width helper.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_AW   = 4;
    localparam int DEF_DW   = 4;

    // Width of a requester index; never below one bit so NREQ=2 still works.
    function automatic int idx_width(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    localparam int DEF_IW = idx_width(DEF_NREQ);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches the request vector starting one
// position after the pointer, wrapping, and reports the first set bit as a
// one-hot grant plus its binary index.
module rr_picker
    import rom_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = DEF_IW
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_found
);

    // Scan candidates ptr+1 .. ptr+NREQ (mod NREQ); the first requester hit wins.
    always_comb begin
        int cand;
        o_grant = {NREQ{1'b0}};
        o_idx   = {IW{1'b0}};
        o_found = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(i_ptr) + k) % NREQ;
            if (!o_found && i_req[cand]) begin
                o_found       = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = cand[IW-1:0];
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing the single read port of a 16x4 ROM between
// NREQ requesters. A grant latches the requester's address, the following
// cycle drives the ROM read, and the captured data is returned with a
// one-cycle valid pulse to the granted requester. Arbitration also runs in
// the response cycle so back-to-back reads complete every two cycles.
// Optional build macro ROM_ARB_STATS_EN adds a saturating read_count output.
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [AW-1:0]      rom_address,
    output logic               rom_rd,
    input  logic [DW-1:0]      rom_out
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [7:0]         read_count
`endif
);

    localparam int IW = idx_width(NREQ);

    arb_state_t        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_win;
    logic [AW-1:0]     r_addr;
    logic              r_rd;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DW-1:0]     r_rsp_data;

    logic [NREQ-1:0]   w_grant;
    logic [IW-1:0]     w_idx;
    logic              w_found;
    logic              w_arb_en;
    logic [AW-1:0]     w_addr;
    logic [NREQ-1:0]   w_win_onehot;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    // A new grant may only be issued while no read is being performed.
    always_comb begin
        if (r_state == READ) begin
            w_arb_en = 1'b0;
        end else begin
            w_arb_en = 1'b1;
        end
    end

    // Grant pulse is combinational so the requester knows its address is taken now.
    always_comb begin
        if (w_arb_en) begin
            req_ready = w_grant;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Select the winning requester's address slice for latching.
    always_comb begin
        w_addr = req_addr[int'(w_idx)*AW +: AW];
    end

    // One-hot form of the latched winner, used for the response pulse.
    always_comb begin
        w_win_onehot        = {NREQ{1'b0}};
        w_win_onehot[r_win] = 1'b1;
    end

    // Arbitration FSM with registered ROM interface and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= IW'(NREQ - 1);
            r_win       <= {IW{1'b0}};
            r_addr      <= {AW{1'b0}};
            r_rd        <= 1'b0;
            r_rsp_valid <= {NREQ{1'b0}};
            r_rsp_data  <= {DW{1'b0}};
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    r_rsp_valid <= {NREQ{1'b0}};
                    if (w_found) begin
                        r_win   <= w_idx;
                        r_ptr   <= w_idx;
                        r_addr  <= w_addr;
                        r_rd    <= 1'b1;
                        r_state <= READ;
                    end else begin
                        r_rd    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                READ: begin
                    r_rsp_data  <= rom_out;
                    r_rd        <= 1'b0;
                    r_rsp_valid <= w_win_onehot;
                    r_state     <= RESP;
                end
                default: begin
                    r_rd        <= 1'b0;
                    r_rsp_valid <= {NREQ{1'b0}};
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rom_address = r_addr;
    assign rom_rd      = r_rd;

`ifdef ROM_ARB_STATS_EN
    logic [7:0] r_read_count;

    // Count delivered responses, saturating at the counter's maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_count <= 8'd0;
        end else if ((|r_rsp_valid) && (r_read_count != 8'd255)) begin
            r_read_count <= r_read_count + 8'd1;
        end else begin
            r_read_count <= r_read_count;
        end
    end

    assign read_count = r_read_count;
`endif

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Shares the single read port of the 16x4 ROM between NREQ requesters.
- Round-robin arbitration; drives the ROM address and rd inputs and captures its combinational output.
- Returns registered data with a per-requester one-cycle valid pulse.
- Sits between the ROM and its client blocks. It is the only driver of the ROM read port.

Parameters:
- NREQ, 4, number of requesters (legal range 2..8)
- AW, 4, ROM address width
- DW, 4, ROM data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset: synchronous and active-high (one clock domain)
- req_valid  in  NREQ  bit i = requester i wants a read
- req_addr  in  NREQ*AW  requester i address at bits [i*AW +: AW]
- req_ready  out  NREQ  one-hot grant pulse; address of the granted requester sampled this cycle
- rsp_valid  out  NREQ  one-hot, one-cycle pulse; rsp_data valid for requester i
- rsp_data  out  DW  registered ROM data, shared by all requesters
- rom_address  out  AW  to ROM address input
- rom_rd  out  1  to ROM rd input
- rom_out  in  DW  from ROM data output (combinational, valid while rom_rd=1)

Behaviour:
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rom_address=0, rom_rd=0, rr pointer=NREQ-1 (so requester 0 wins first).
- FSM states: IDLE, READ, RESP.
- Arbitration (in IDLE or RESP):
  - If any req_valid bit is set, the winner is the first set bit searching from (ptr+1) mod NREQ upward, wrapping.
  - req_ready[winner]=1 combinationally in that cycle.
  - At the clock edge: latch winner index and req_addr slice; ptr<=winner; next state READ.
  - If no request: from RESP go to IDLE, from IDLE stay in IDLE.
- READ:
  - rom_rd=1 and rom_address=latched address for exactly one cycle.
  - At the edge: rsp_data<=rom_out; next state RESP.
- RESP:
  - rsp_valid[winner]=1 for this cycle only.
  - Arbitration for the next read runs in the same cycle, so back-to-back reads complete every 2 cycles.
- rom_rd=0 outside READ. rom_address holds its last value (no glitching to 0). rsp_data holds until the next capture.
- Latency: grant cycle G -> rsp_valid in cycle G+2.
- req_ready is never asserted in READ. No more than one read is outstanding.
- Requesters may drop req_valid after their req_ready. Address changes after grant have no effect on the read in progress.
- Requester i re-requesting immediately is served only after all other pending requesters (fairness: at most NREQ-1 intervening grants).
- Reset asserted in any state returns everything to reset values at the next edge. An in-flight read is discarded with no rsp_valid.
- rst has priority over all other events in the same cycle.

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- Defined:
  - Adds output port read_count [7:0].
  - Increments on each rsp_valid pulse and saturates at 255.
  - Reset to 0 by rst.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package rom_arb_pkg: state enum typedef (IDLE, READ, RESP), default AW/DW constants, and a log2-of-NREQ index-width constant.
- Sub-module rr_picker: combinational. Inputs: req vector and pointer. Outputs: one-hot grant and winner index.
- The FSM, datapath and ROM interface stay in rom_rr_arbiter.

Test Plan:
- ROM preload addr0=0, addr1=1, addr2=2. Stimulus: after reset, req_valid=0001, addr0=2 -> req_ready=0001 at cycle 0, rom_rd=1 with rom_address=2 at cycle 1, rsp_valid=0001 with rsp_data=2 at cycle 2.
- All four requesters held active with addresses 0,1,2,1 -> grant order 0,1,2,3,0, grants every 2 cycles; rsp_data sequence 0,1,2,1,0.
- Requester 2 alone, then 1 and 3 together -> grants 2, then 3, then 1 (search wraps past ptr).
- rst asserted during READ -> next cycle all outputs at reset values; no rsp_valid for the discarded read. Next single request from requester 1 is granted with ptr back at 3.
- Requester changes req_addr from 1 to 2 the cycle after its grant -> rsp_data=1. rom_rd is high for exactly 1 cycle per grant.
- With ROM_ARB_STATS_EN: 300 back-to-back reads -> read_count=255. Without the macro the design compiles with no read_count port.
